fifo_write_arbiter: RTL and testbench

- Shares the single write port of one fifo instance (input_data/write/full) among NUM_REQ requesters.
- Uses round-robin arbitration with bounded bursts: a winner keeps the port for up to MAX_BURST consecutive beats, then the port is re-arbitrated.
- Sits directly in front of the fifo's write side; the fifo read side is untouched.

---
 rtl/fifo_write_arbiter.sv | 114 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-limited arbiter sharing one fifo write port.
// Ports: clk, reset(n), req/req_data in, accept/fifo_write/fifo_data out, fifo_full in, busy/owner_id.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 11,
  parameter int MAX_BURST = 4,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           accept,
  input  logic                         fifo_full,
  output logic                         fifo_write,
  output logic [DATA_BITS-1:0]         fifo_data,
  output logic                         busy,
  output logic [OW-1:0]                owner_id
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state;
  logic [OW-1:0] rr_ptr;
  logic [3:0]    beat_cnt;
  logic [3:0]    beat_nxt;
  logic          last_beat;
  logic [OW-1:0] win;
  logic          found;
  int            idx;

  assign beat_nxt  = beat_cnt + 4'd1;
  assign last_beat = (beat_nxt == 4'(MAX_BURST));

  // First requester after the last winner, wrapping around.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = OW'(idx);
      end
    end
  end

  // Grant is combinational; reset low suppresses any beat.
  always_comb begin
    accept = '0;
    if (reset && !fifo_full) begin
      unique case (state)
        IDLE:  if (found) accept[win] = 1'b1;
        BURST: if (req[owner_id]) accept[owner_id] = 1'b1;
        default: accept = '0;
      endcase
    end
  end

  assign fifo_write = |accept;

  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) fifo_data = req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner_id <= '0;
      beat_cnt <= '0;
      rr_ptr   <= OW'(NUM_REQ - 1);
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_full && found) begin
            owner_id <= win;
            rr_ptr   <= win;
            beat_cnt <= 4'd1;
            if (MAX_BURST > 1) begin
              state <= BURST;
              busy  <= 1'b1;
            end
          end
        end
        BURST: begin
          if (!req[owner_id]) begin
            // Requester gave up: bubble, then re-arbitrate.
            state    <= IDLE;
            busy     <= 1'b0;
            beat_cnt <= '0;
            rr_ptr   <= owner_id;
          end else if (!fifo_full) begin
            beat_cnt <= beat_nxt;
            if (last_beat) begin
              state  <= IDLE;
              busy   <= 1'b0;
              rr_ptr <= owner_id;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed vector bench for fifo_write_arbiter.
// Table of per-cycle stimulus/expectations plus reset and single-beat sequences.
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [43:0] req_data = '0;
  logic        fifo_full = 1'b0;
  logic [3:0]  accept, accept1;
  logic        fifo_write, fifo_write1;
  logic [10:0] fifo_data, fifo_data1;
  logic        busy, busy1;
  logic [1:0]  owner_id, owner_id1;

  int n_vec = 0;
  int n_bad = 0;

  always #10 clk = ~clk;

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_BITS(11), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .accept(accept), .fifo_full(fifo_full), .fifo_write(fifo_write),
    .fifo_data(fifo_data), .busy(busy), .owner_id(owner_id)
  );

  fifo_write_arbiter #(.NUM_REQ(4), .DATA_BITS(11), .MAX_BURST(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .accept(accept1), .fifo_full(fifo_full), .fifo_write(fifo_write1),
    .fifo_data(fifo_data1), .busy(busy1), .owner_id(owner_id1)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic        full;
    logic [43:0] data;
    logic [3:0]  acc;
    logic [10:0] fd;
    logic        bsy;
    logic [1:0]  own;
  } vec_t;

  vec_t tv[$];

  function automatic logic [43:0] pk(input int d3, d2, d1, d0);
    return {11'(d3), 11'(d2), 11'(d1), 11'(d0)};
  endfunction

  function automatic void add(input logic r, input logic [3:0] q,
                              input logic f, input logic [43:0] d,
                              input logic [3:0] a, input int x,
                              input logic b, input int o);
    vec_t v;
    v.rst = r; v.rq = q; v.full = f; v.data = d;
    v.acc = a; v.fd = 11'(x); v.bsy = b; v.own = 2'(o);
    tv.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [43:0] act,
                     input logic [43:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_main(input string tag, input logic [3:0] a,
                          input logic [10:0] d, input logic b,
                          input logic [1:0] o);
    chk({tag, ".accept"}, 44'(accept), 44'(a));
    chk({tag, ".write"}, 44'(fifo_write), 44'(|a));
    chk({tag, ".data"}, 44'(fifo_data), 44'(d));
    chk({tag, ".busy"}, 44'(busy), 44'(b));
    chk({tag, ".owner"}, 44'(owner_id), 44'(o));
  endtask

  initial begin
    logic [43:0] d1, d2, d3, d4;
    d1 = pk(0, 0, 0, 5);
    d2 = pk(3, 2, 1, 0);
    d3 = pk(0, 0, 7, 9);
    d4 = pk(3, 2, 0, 0);

    // single requester: 4-beat burst, re-grant, then drop
    add(0, 4'b0001, 0, d1, 4'b0000, 0, 0, 0);
    add(1, 4'b0001, 0, d1, 4'b0001, 5, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 4'b0001, 0, d1, 4'b0001, 5, 1, 0);
    add(1, 4'b0001, 0, d1, 4'b0001, 5, 0, 0);
    add(1, 4'b0001, 0, d1, 4'b0001, 5, 1, 0);
    add(1, 4'b0000, 0, d1, 4'b0000, 0, 1, 0);
    add(1, 4'b0000, 0, d1, 4'b0000, 0, 0, 0);

    // all requesting: 0,1,2,3,0 rotation
    add(0, 4'b0000, 0, d2, 4'b0000, 0, 0, 0);
    for (int g = 0; g < 5; g++) begin
      add(1, 4'b1111, 0, d2, 4'(1 << (g % 4)), g % 4, 0,
          (g == 0) ? 0 : (g - 1) % 4);
      for (int b = 0; b < 3; b++)
        add(1, 4'b1111, 0, d2, 4'(1 << (g % 4)), g % 4, 1, g % 4);
    end
    add(1, 4'b0000, 0, d2, 4'b0000, 0, 0, 0);

    // requester 1 stalled by full, non-owner ignored
    add(1, 4'b0011, 0, d3, 4'b0010, 7, 0, 0);
    add(1, 4'b0011, 0, d3, 4'b0010, 7, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 4'b0011, 1, d3, 4'b0000, 0, 1, 1);
    add(1, 4'b0011, 0, d3, 4'b0010, 7, 1, 1);
    add(1, 4'b0011, 0, d3, 4'b0010, 7, 1, 1);
    add(1, 4'b0011, 1, d3, 4'b0000, 0, 0, 1);
    add(1, 4'b0011, 0, d3, 4'b0001, 9, 0, 1);
    add(1, 4'b0000, 0, d3, 4'b0000, 0, 1, 0);
    add(1, 4'b0000, 0, d3, 4'b0000, 0, 0, 0);

    // requester 2 drops after one beat, 3 takes over
    add(1, 4'b1100, 0, d4, 4'b0100, 2, 0, 0);
    add(1, 4'b1000, 0, d4, 4'b0000, 0, 1, 2);
    add(1, 4'b1000, 0, d4, 4'b1000, 3, 0, 2);
    add(1, 4'b1000, 0, d4, 4'b1000, 3, 1, 3);
    add(1, 4'b0000, 0, d4, 4'b0000, 0, 1, 3);
    add(1, 4'b0000, 0, d4, 4'b0000, 0, 0, 3);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      reset = tv[i].rst;
      req = tv[i].rq;
      fifo_full = tv[i].full;
      req_data = tv[i].data;
      #1;
      chk_main($sformatf("v%0d", i), tv[i].acc, tv[i].fd,
               tv[i].bsy, tv[i].own);
    end

    // asynchronous reset during beat 2 of requester 0
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    req = 4'b0001;
    req_data = pk(0, 0, 0, 5);
    #1 chk_main("rst.beat1", 4'b0001, 11'd5, 1'b0, 2'd0);
    @(negedge clk);
    #1 chk_main("rst.beat2", 4'b0001, 11'd5, 1'b1, 2'd0);
    reset = 1'b0;
    #1 chk_main("rst.low", 4'b0000, 11'd0, 1'b0, 2'd0);
    #2;
    reset = 1'b1;
    req = 4'b0101;
    req_data = pk(0, 6, 0, 5);
    #1 chk_main("rst.regrant", 4'b0001, 11'd5, 1'b0, 2'd0);
    @(negedge clk);
    req = '0;

    // single-beat grants alternate with no bubbles
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    req = 4'b0011;
    req_data = pk(0, 0, 6, 4);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mb1.acc%0d", i), 44'(accept1),
          44'((i % 2 == 0) ? 4'b0001 : 4'b0010));
      chk($sformatf("mb1.data%0d", i), 44'(fifo_data1),
          44'((i % 2 == 0) ? 11'd4 : 11'd6));
      chk($sformatf("mb1.wr%0d", i), 44'(fifo_write1), 44'(1));
      chk($sformatf("mb1.busy%0d", i), 44'(busy1), 44'(0));
      chk($sformatf("mb1.own%0d", i), 44'(owner_id1),
          44'((i == 2) ? 1 : 0));
      @(negedge clk);
    end
    req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
